// File: rtl/riscv_rf_pkg.sv
// Shared types and helpers for the multi-port register file.
package riscv_rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_clr_state_e;

    // Ceiling log2, used to size the clear-sweep index.
    function automatic int rf_clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/riscv_rf_wr_arb.sv
// Per-word write arbitration: the highest-index enabled port whose address
// matches a word wins that word. One instance feeds both storage and the
// same-cycle forwarding path so the two can never disagree.
module riscv_rf_wr_arb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WPORTS = 2,
    parameter int NUM_WORDS  = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0]          i_waddr,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0]          i_wdata,
    input  logic [NUM_WPORTS-1:0]                     i_we,
    input  logic                                      i_en,
    output logic [NUM_WORDS-1:0]                      o_word_we,
    output logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]      o_word_wdata
);

    // Later ports overwrite earlier ones, giving higher index priority;
    // word 0 never accepts a write when it is the hardwired zero.
    always_comb begin
        o_word_we    = '0;
        o_word_wdata = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (i_en && i_we[p] && (i_waddr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(w))
                    && !(ZERO_REG != 0 && w == 0)) begin
                    o_word_we[w]    = 1'b1;
                    o_word_wdata[w] = i_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/riscv_register_file_mp.sv
// Flip-flop register file with N read / M write ports, optional write-to-read
// forwarding, a pending-load scoreboard and a sequential clear engine.
module riscv_register_file_mp
    import riscv_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int FWD_EN     = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0]   raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_RPORTS-1:0]              busy_o,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0]   waddr_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_WPORTS-1:0]              we_i,
    input  logic                               rsv_i,
    input  logic [ADDR_WIDTH-1:0]              rsv_addr_i,
    input  logic                               clr_req_i,
    output logic                               clr_busy_o,
    output logic                               clr_done_o
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int IW        = rf_clog2(NUM_WORDS);
    localparam logic [IW-1:0] IDX_START = IW'(ZERO_REG);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_WORDS - 1);

    rf_clr_state_e                       r_state;
    logic [IW-1:0]                       r_idx;
    logic                                r_clr_busy;
    logic                                r_clr_done;

    logic                                w_sweep;
    logic [NUM_WORDS-1:0]                w_word_we;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] w_word_wdata;
    logic [DATA_WIDTH-1:0]               w_rf   [NUM_WORDS];
    logic                                w_pend [NUM_WORDS];

    assign w_sweep    = (r_state == RF_SWEEP);
    assign clr_busy_o = r_clr_busy;
    assign clr_done_o = r_clr_done;

    // Writes are gated off during a sweep, which also kills forwarding.
    riscv_rf_wr_arb #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WPORTS (NUM_WPORTS),
        .NUM_WORDS  (NUM_WORDS),
        .ZERO_REG   (ZERO_REG)
    ) u_wr_arb (
        .i_waddr      (waddr_i),
        .i_wdata      (wdata_i),
        .i_we         (we_i),
        .i_en         (!w_sweep),
        .o_word_we    (w_word_we),
        .o_word_wdata (w_word_wdata)
    );

    // Clear engine: walk idx from the first writable word to the last; the
    // done pulse is registered so it lines up with the final clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RF_IDLE;
            r_idx      <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            case (r_state)
                RF_IDLE: begin
                    r_clr_done <= 1'b0;
                    if (clr_req_i) begin
                        r_state    <= RF_SWEEP;
                        r_idx      <= IDX_START;
                        r_clr_busy <= 1'b1;
                        r_clr_done <= (IDX_START == IDX_LAST);
                    end
                end
                RF_SWEEP: begin
                    if (r_idx == IDX_LAST) begin
                        r_state    <= RF_IDLE;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b0;
                    end else begin
                        r_idx      <= r_idx + 1'b1;
                        r_clr_done <= ((r_idx + 1'b1) == IDX_LAST);
                    end
                end
                default: begin
                    r_state    <= RF_IDLE;
                    r_clr_busy <= 1'b0;
                    r_clr_done <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
        if (ZERO_REG != 0 && g == 0) begin : g_zero
            assign w_rf[g]   = '0;
            assign w_pend[g] = 1'b0;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_data;
            logic                  r_pend;
            logic                  w_clr;
            logic                  w_rsv;

            assign w_clr = w_sweep && (r_idx == IW'(g));
            assign w_rsv = !w_sweep && rsv_i && (rsv_addr_i == ADDR_WIDTH'(g));

            // Word storage: sweep clear beats any write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)            r_data <= '0;
                else if (w_clr)        r_data <= '0;
                else if (w_word_we[g]) r_data <= w_word_wdata[g];
            end

            // Pending bit: a reserve outranks a same-cycle write to the word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)            r_pend <= 1'b0;
                else if (w_clr)        r_pend <= 1'b0;
                else if (w_rsv)        r_pend <= 1'b1;
                else if (w_word_we[g]) r_pend <= 1'b0;
            end

            assign w_rf[g]   = r_data;
            assign w_pend[g] = r_pend;
        end
    end

    for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_a;
        logic                  w_fwd;
        assign w_a   = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_fwd = (FWD_EN != 0) && w_word_we[w_a];
        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = w_fwd ? w_word_wdata[w_a] : w_rf[w_a];
        assign busy_o[k] = w_pend[w_a] & ~w_fwd;
    end

endmodule
